// File: rtl/down_timer.sv
// Loadable down-counting timer: counts a loaded period down on each tick enable and
// emits a one-clock done pulse on expiry, either stopping (one-shot) or reloading (periodic).
module down_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_q,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_reload;
  logic             r_mode;
  logic             r_busy;
  logic             r_done;

  state_e           w_state_d;
  logic [WIDTH-1:0] w_q_d;
  logic [WIDTH-1:0] w_reload_d;
  logic             w_mode_d;
  logic             w_done_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_q      <= '0;
      r_reload <= '0;
      r_mode   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_q      <= w_q_d;
      r_reload <= w_reload_d;
      r_mode   <= w_mode_d;
      r_busy   <= (w_state_d == StRun);
      r_done   <= w_done_d;
    end
  end

  // Stop outranks start, which outranks the tick; a start in RUN discards that clock's tick.
  always_comb begin
    w_state_d  = r_state;
    w_q_d      = r_q;
    w_reload_d = r_reload;
    w_mode_d   = r_mode;
    w_done_d   = 1'b0;
    if ((r_state == StRun) && i_stop) begin
      w_state_d = StIdle;
    end else if (i_start && !i_stop) begin
      if (i_load_val != '0) begin
        w_q_d      = i_load_val;
        w_reload_d = i_load_val;
        w_mode_d   = i_mode;
        w_state_d  = StRun;
      end else begin
        w_q_d     = '0;
        w_done_d  = 1'b1;
        w_state_d = StIdle;
      end
    end else if ((r_state == StRun) && i_en) begin
      if (r_q == WIDTH'(1)) begin
        w_done_d = 1'b1;
        if (r_mode) begin
          w_q_d = r_reload;
        end else begin
          w_q_d     = '0;
          w_state_d = StIdle;
        end
      end else begin
        w_q_d = r_q - WIDTH'(1);
      end
    end
  end

  always_comb begin
    o_q    = r_q;
    o_busy = r_busy;
    o_done = r_done;
  end

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer: expected {q,busy,done} is queued as each step is driven
// and popped for comparison one time unit after the following rising edge.
module tb_down_timer;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         stop;
  logic         mode;
  logic [W-1:0] load_val;
  logic         en;
  logic [W-1:0] q;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_errors = 0;

  logic [W+1:0] exp_q[$];
  string        tag_q[$];

  down_timer #(.WIDTH(W)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_stop     (stop),
    .i_mode     (mode),
    .i_load_val (load_val),
    .i_en       (en),
    .o_q        (q),
    .o_busy     (busy),
    .o_done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_out(input string tag, input logic [W-1:0] eq, input logic eb,
                            input logic ed);
    exp_q.push_back({eq, eb, ed});
    tag_q.push_back(tag);
  endtask

  task automatic check_front();
    logic [W+1:0] obs;
    logic [W+1:0] exp;
    string        tag;
    obs = {q, busy, done};
    exp = exp_q.pop_front();
    tag = tag_q.pop_front();
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed q=%0d busy=%0b done=%0b, expected q=%0d busy=%0b done=%0b",
             tag, obs[W+1:2], obs[1], obs[0], exp[W+1:2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input logic s, input logic p, input logic m, input logic [W-1:0] lv,
                       input logic e);
    start    = s;
    stop     = p;
    mode     = m;
    load_val = lv;
    en       = e;
  endtask

  // Push the expectation for the coming edge, then sample just after it.
  task automatic tick(input string tag, input logic [W-1:0] eq, input logic eb, input logic ed);
    expect_out(tag, eq, eb, ed);
    @(posedge clk);
    #1;
    check_front();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    #1;
    expect_out("reset_init", 8'd0, 1'b0, 1'b0);
    check_front();
    #11;
    rst_n = 1'b1;

    // One-shot, L=4, continuous en
    drive(1'b1, 1'b0, 1'b0, 8'd4, 1'b1); tick("os_load", 8'd4, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'd4, 1'b1); tick("os_q3", 8'd3, 1'b1, 1'b0);
    tick("os_q2", 8'd2, 1'b1, 1'b0);
    tick("os_q1", 8'd1, 1'b1, 1'b0);
    tick("os_expire", 8'd0, 1'b0, 1'b1);
    tick("os_idle", 8'd0, 1'b0, 1'b0);

    // Periodic, L=3, en every other clock; mid-run mode/load_val changes ignored
    drive(1'b1, 1'b0, 1'b1, 8'd3, 1'b0); tick("per_load", 8'd3, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 8'd3, 1'b0); tick("per_a0", 8'd3, 1'b1, 1'b0);
    en = 1'b1; tick("per_a1", 8'd2, 1'b1, 1'b0);
    en = 1'b0; tick("per_a2", 8'd2, 1'b1, 1'b0);
    en = 1'b1; tick("per_a3", 8'd1, 1'b1, 1'b0);
    en = 1'b0; tick("per_a4", 8'd1, 1'b1, 1'b0);
    en = 1'b1; tick("per_exp1", 8'd3, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 8'd9, 1'b0); tick("per_b0", 8'd3, 1'b1, 1'b0);
    en = 1'b1; tick("per_b1", 8'd2, 1'b1, 1'b0);
    en = 1'b0; tick("per_b2", 8'd2, 1'b1, 1'b0);
    en = 1'b1; tick("per_b3", 8'd1, 1'b1, 1'b0);
    en = 1'b0; tick("per_b4", 8'd1, 1'b1, 1'b0);
    en = 1'b1; tick("per_exp2", 8'd3, 1'b1, 1'b1);

    // Stop together with en at q=1
    tick("stp_q2", 8'd2, 1'b1, 1'b0);
    tick("stp_q1", 8'd1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 8'd0, 1'b1); tick("stp_abort", 8'd1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b1); tick("stp_idle_en", 8'd1, 1'b0, 1'b0);

    // Start with en at q=2 discards the tick; then restart at q=7 with L=2
    drive(1'b1, 1'b0, 1'b0, 8'd5, 1'b1); tick("rs_load5", 8'd5, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'd5, 1'b1); tick("rs_q4", 8'd4, 1'b1, 1'b0);
    tick("rs_q3", 8'd3, 1'b1, 1'b0);
    tick("rs_q2", 8'd2, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 8'd9, 1'b1); tick("rs_load9", 8'd9, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'd9, 1'b1); tick("rs_q8", 8'd8, 1'b1, 1'b0);
    tick("rs_q7", 8'd7, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 8'd2, 1'b1); tick("rs_load2", 8'd2, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 8'd6, 1'b1); tick("rs_q1", 8'd1, 1'b1, 1'b0);
    tick("rs_expire", 8'd0, 1'b0, 1'b1);
    tick("rs_idle", 8'd0, 1'b0, 1'b0);

    // Zero-length start from IDLE and from RUN
    drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0); tick("z_idle", 8'd0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0); tick("z_idle_after", 8'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 8'd6, 1'b0); tick("z_run_load", 8'd6, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b1); tick("z_run", 8'd0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b1); tick("z_run_after", 8'd0, 1'b0, 1'b0);

    // Maximum period: 255 ticks to expiry
    drive(1'b1, 1'b0, 1'b0, 8'd255, 1'b1); tick("max_load", 8'd255, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'd255, 1'b1);
    for (int i = 1; i < 255; i++) begin
      tick("max_count", 8'(255 - i), 1'b1, 1'b0);
    end
    tick("max_expire", 8'd0, 1'b0, 1'b1);
    tick("max_idle", 8'd0, 1'b0, 1'b0);

    // Periodic with reload 1: done on every tick
    drive(1'b1, 1'b0, 1'b1, 8'd1, 1'b0); tick("p1_load", 8'd1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'd1, 1'b1); tick("p1_exp1", 8'd1, 1'b1, 1'b1);
    tick("p1_exp2", 8'd1, 1'b1, 1'b1);

    // Async reset with done pending cancels it immediately
    rst_n = 1'b0;
    #2;
    expect_out("rst_cancel_done", 8'd0, 1'b0, 1'b0);
    check_front();
    #8;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    @(posedge clk);
    #1;

    // Async reset mid-count at q=5
    drive(1'b1, 1'b0, 1'b0, 8'd5, 1'b0); tick("rst_load5", 8'd5, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'd5, 1'b0); tick("rst_hold5", 8'd5, 1'b1, 1'b0);
    rst_n = 1'b0;
    #2;
    expect_out("rst_immediate", 8'd0, 1'b0, 1'b0);
    check_front();
    #10;
    expect_out("rst_held", 8'd0, 1'b0, 1'b0);
    check_front();
    rst_n = 1'b1;
    en = 1'b1;
    tick("rst_idle_en1", 8'd0, 1'b0, 1'b0);
    tick("rst_idle_en2", 8'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/down_timer.md
# down_timer

Loadable down-counting timer driven by a tick enable, used wherever the design needs a programmable delay or a periodic strobe.
- A `start` loads a period of L ticks and counts `q` down once per `en`.
- A one-clock `done` pulse fires when the count expires.
- In one-shot mode the timer then returns to idle; in periodic mode it reloads and keeps running.
- It sits downstream of prescaler/mod-N tick sources, consuming their carry pulse on `en`.

## Interface
- `WIDTH`, default 8 — width of the period and count registers.
- `clk`  in  1  — system clock; all state changes on its rising edge.
- `rst`  in  1  — reset, asynchronous, active-low; clears all state immediately when 0.
- `start`  in  1  — load `load_val`/`mode` and begin (or restart) counting.
- `stop`  in  1  — abort counting; return to idle without `done`.
- `mode`  in  1  — 0 = one-shot, 1 = periodic; captured on accepted `start`.
- `load_val`  in  WIDTH  — period L in `en` ticks; captured on accepted `start`.
- `en`  in  1  — count tick; one decrement per clock where `en`=1 while running.
- `q`  out  WIDTH  — current count (registered).
- `busy`  out  1  — 1 while in RUN (registered).
- `done`  out  1  — one-clock pulse on expiry (registered).

## Operation
- Internal registers: `state` ∈ {IDLE, RUN}, `reload` (WIDTH bits), `mode_r` (1 bit).
- Reset (`rst`=0, asynchronous): `state`=IDLE, `q`=0, `busy`=0, `done`=0, `reload`=0, `mode_r`=0.
- `done` defaults to 0 every clock. It is 1 only in the clock after an expiry or a zero-length start.
- Priority within one clock: `stop` > `start` > `en` tick.
- IDLE, `start`=1, `load_val`≠0:
  - `q` ← `load_val`, `reload` ← `load_val`, `mode_r` ← `mode`.
  - `state` ← RUN, `busy` ← 1.
- IDLE, `start`=1, `load_val`=0 (zero-length):
  - `done` ← 1, `q` ← 0.
  - `state` stays IDLE, `busy` stays 0.
- IDLE, no `start`: `q` holds its last value, `en` is ignored.
- RUN, `stop`=1:
  - `state` ← IDLE, `busy` ← 0.
  - `q` holds its current value, no `done`. Any simultaneous `start`/`en` is ignored.
- RUN, `start`=1 (no `stop`): restart.
  - Identical to the IDLE start rules, including the `load_val`=0 case, which goes to IDLE with a `done` pulse.
  - The tick in the same clock is discarded.
- RUN, `en`=1, `q`>1: `q` ← `q`−1.
- RUN, `en`=1, `q`=1: expiry, `done` ← 1.
  - `mode_r`=0: `q` ← 0, `state` ← IDLE, `busy` ← 0.
  - `mode_r`=1: `q` ← `reload`, stays RUN.
- RUN, `en`=0: hold all state.
- Period: exactly L `en` ticks from start to expiry. Periodic expiries are L ticks apart; `reload` value 1 gives `done` on every tick.
- Arithmetic:
  - Decrement is unsigned, WIDTH bits.
  - `q`=0 never occurs in RUN, so there is no underflow/wrap.
  - Maximum period is 2^WIDTH−1.
- Changing `mode`/`load_val` while running has no effect until the next accepted `start`.

## Timing
- Accepted `start` at edge k: from edge k on, `q`=L and `busy`=1.
- With `en`=1 continuously from edge k+1, one-shot:
  - Expiry at edge k+L: `q`=0, `busy`=0, `done`=1.
  - `done` returns to 0 at edge k+L+1.
- Periodic, `en` continuous: `done` is high after edges k+L, k+2L, …, each time for one clock. `q` reads L right after each expiry.
- Zero-length start at edge k: `done`=1 during cycle k..k+1 only.
- Asynchronous reset mid-run: all outputs clear immediately.
  - A pending `done` is cancelled.
  - After reset is released, the timer stays in IDLE until a new `start`.
- `start` held high for several clocks restarts on each clock, so `q` sticks at L. Callers pulse `start` for one clock.

## Test plan
- Reset: assert `rst`=0 mid-count (`q`=5, RUN) → immediately `q`=0, `busy`=0, `done`=0; stays IDLE after release with `en`=1.
- One-shot: WIDTH=8, `start` with `load_val`=4, `mode`=0, `en`=1 continuous:
  - `q` sequence after each edge: 4,3,2,1,0.
  - `done`=1 for exactly one clock, coincident with `q`=0; `busy` falls at the same edge.
- Periodic with gapped `en`: `load_val`=3, `mode`=1, `en` high every other clock → `done` pulses every 6 clocks; `q` cycles 3,2,1,3,…; `busy` stays 1.
- Stop/priority:
  - `stop` and `en` together at `q`=1 → IDLE, `q`=1, no `done`.
  - `start` (`load_val`=9) with `en` at `q`=2 → `q`=9, no decrement.
- Zero/max: `load_val`=0 → single `done` pulse, `busy` never 1; `load_val`=255 → expiry after exactly 255 ticks.
- Restart: `start` at `q`=7 with `load_val`=2, `mode`=0 → expiry 2 ticks later; a `mode`/`load_val` change mid-run has no effect.
